// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the fetch-entry payload and the address-legality helper.
package imem_fetch_ctrl_pkg;

    localparam int unsigned IMEM_SIZE = 1024;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // A fetch address is illegal when outside memory or not word-aligned.
    function automatic logic fetch_addr_bad(input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] limit);
        return (pc >= limit) || (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: instruction memory port, IF/ID handshake,
// redirect/halt controls and fault/status reporting.
interface imem_fetch_ctrl_if;
    import imem_fetch_ctrl_pkg::*;

    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] idata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_pc;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output iaddr, out_valid, out_instr, out_pc, fetch_fault, fault_pc, fetch_count,
        input  idata, out_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  iaddr, out_valid, out_instr, out_pc, fetch_fault, fault_pc, fetch_count,
        output idata, out_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Parameterised synchronous circular-buffer FIFO with flush.
// Head data reads as zero while empty.
module imem_fetch_ctrl_fetch_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches into a prefetch FIFO,
// handles redirect, halt and sticky range/alignment faults.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     DEPTH      = 2,
    parameter int unsigned     IMEM_BYTES = IMEM_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    imem_fetch_ctrl_if.master   bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic            fault;
    logic [XLEN-1:0] fault_pc_q;
    logic [XLEN-1:0] fetch_count_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    logic            deq;
    logic            space;
    logic            attempt;
    logic            bad;
    logic            push;

    assign deq     = !fifo_empty && bus.out_ready;
    assign space   = (fifo_count < CW'(DEPTH)) || (fifo_full && deq);
    assign attempt = !bus.redirect_valid && !bus.halt && !fault && space;
    assign bad     = fetch_addr_bad(pc, XLEN'(IMEM_BYTES));
    assign push    = attempt && !bad;
    assign wr_entry = '{pc: pc, instr: bus.idata};

    imem_fetch_ctrl_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (deq),
        .wdata (wr_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PC, fault flag and fetch counter; priority rst > redirect > fault > halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            fault         <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            fault <= 1'b0;
        end else if (attempt) begin
            if (bad) begin
                fault      <= 1'b1;
                fault_pc_q <= pc;
            end else begin
                pc            <= pc + XLEN'(4);
                fetch_count_q <= fetch_count_q + XLEN'(1);
            end
        end
    end

    assign bus.iaddr       = pc;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_pc      = head.pc;
    assign bus.out_instr   = head.instr;
    assign bus.fetch_fault = fault;
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl (DEPTH=2, 128-byte memory).
module tb_imem_fetch_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .DEPTH      (2),
        .IMEM_BYTES (128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Memory model: word k holds k*0x11111111, address truncated to 32 words.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] k;
        k = (a >> 2) & 32'd31;
        return k * 32'h1111_1111;
    endfunction

    assign bus.idata = word_at(bus.iaddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = a;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);
        check("rst_fault_pc", bus.fault_pc, 32'd0);
        check("rst_count", bus.fetch_count, 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);

        // Streaming with out_ready held high
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("stream_iaddr", bus.iaddr, 32'(4 * c));
            if (c == 0) begin
                check("stream_valid0", 32'(bus.out_valid), 32'd0);
            end else begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_pc", bus.out_pc, 32'(4 * (c - 1)));
                check("stream_instr", bus.out_instr, word_at(32'(4 * (c - 1))));
            end
            tick();
        end
        check("stream_count", bus.fetch_count, 32'd6);

        // Backpressure: FIFO fills with pc 0,4 and pc holds at 8
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        check("bp_head", bus.out_pc, 32'd0);
        check("bp_iaddr", bus.iaddr, 32'd8);
        check("bp_count", bus.fetch_count, 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_pc", bus.out_pc, 32'(4 * i));
            if (i < 2) tick();
        end

        // Redirect to 0x40 while FIFO holds pc 8,12
        redirect_to(32'h40);
        check("redir_valid0", 32'(bus.out_valid), 32'd0);
        check("redir_iaddr", bus.iaddr, 32'h40);
        tick();
        check("redir_valid1", 32'(bus.out_valid), 32'd1);
        check("redir_pc", bus.out_pc, 32'h40);
        check("redir_instr", bus.out_instr, 32'h1111_1110);
        tick();
        check("redir_pc2", bus.out_pc, 32'h44);

        // Run off the end of memory
        redirect_to(32'h78);
        check("end_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        check("end_pc78", bus.out_pc, 32'h78);
        tick();
        check("end_pc7c", bus.out_pc, 32'h7C);
        check("end_instr", bus.out_instr, word_at(32'h7C));
        check("end_nofault", 32'(bus.fetch_fault), 32'd0);
        tick();
        check("end_fault", 32'(bus.fetch_fault), 32'd1);
        check("end_fault_pc", bus.fault_pc, 32'h80);
        check("end_valid", 32'(bus.out_valid), 32'd0);
        check("end_count", bus.fetch_count, 32'd8);
        tick();
        tick();
        check("end_count_hold", bus.fetch_count, 32'd8);
        check("end_iaddr_hold", bus.iaddr, 32'h80);
        check("end_valid_hold", 32'(bus.out_valid), 32'd0);
        redirect_to(32'h0);
        check("clr_fault", 32'(bus.fetch_fault), 32'd0);
        check("clr_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        check("clr_valid1", 32'(bus.out_valid), 32'd1);
        check("clr_pc", bus.out_pc, 32'h0);
        check("clr_count", bus.fetch_count, 32'd9);

        // Misaligned redirect
        redirect_to(32'h42);
        check("mis_nofault", 32'(bus.fetch_fault), 32'd0);
        check("mis_iaddr", bus.iaddr, 32'h42);
        tick();
        check("mis_fault", 32'(bus.fetch_fault), 32'd1);
        check("mis_fault_pc", bus.fault_pc, 32'h42);
        check("mis_valid", 32'(bus.out_valid), 32'd0);
        check("mis_count", bus.fetch_count, 32'd9);
        tick();
        check("mis_count_hold", bus.fetch_count, 32'd9);
        redirect_to(32'h0);
        check("mis_clr", 32'(bus.fetch_fault), 32'd0);
        tick();
        check("run_valid", 32'(bus.out_valid), 32'd1);

        // Reset mid-run
        rst = 1'b1;
        tick();
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_count", bus.fetch_count, 32'd0);
        check("mrst_fault", 32'(bus.fetch_fault), 32'd0);
        check("mrst_fault_pc", bus.fault_pc, 32'd0);
        check("mrst_iaddr", bus.iaddr, 32'd0);
        check("mrst_out_pc", bus.out_pc, 32'd0);

        // Halt drains the FIFO without fetching
        rst = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("halt_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.halt = 1'b1;
        bus.out_ready = 1'b1;
        for (int h = 0; h < 3; h++) begin
            check("halt_iaddr", bus.iaddr, 32'd8);
            check("halt_count", bus.fetch_count, 32'd2);
            if (h == 1) check("halt_pc", bus.out_pc, 32'd4);
            if (h == 2) check("halt_empty", 32'(bus.out_valid), 32'd0);
            tick();
        end
        bus.halt = 1'b0;
        check("resume_iaddr", bus.iaddr, 32'd8);
        tick();
        check("resume_valid", 32'(bus.out_valid), 32'd1);
        check("resume_pc", bus.out_pc, 32'd8);
        check("resume_count", bus.fetch_count, 32'd3);
        check("resume_iaddr2", bus.iaddr, 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch controller that sequences the instruction memory for the pipeline front end. It owns the PC and drives the instruction memory's address port. It captures the combinational read data into a small prefetch FIFO and presents {pc, instr} to the IF/ID stage with a valid/ready handshake. It also handles redirects (branch/jump/exception), halt, and out-of-range or misaligned fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, prefetch FIFO entries; power of two, 2..8.
IMEM_BYTES, `IMEM_SIZE, instruction memory size in bytes; legal fetch range is 0..IMEM_BYTES-1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
iaddr  out  32  byte address to the instruction memory; equals the internal PC.
idata  in  32  combinational read data from the instruction memory for iaddr, valid in the same cycle.
out_valid  out  1  FIFO head holds a fetched instruction.
out_ready  in  1  IF/ID stage accepts the head this cycle.
out_instr  out  32  head instruction word.
out_pc  out  32  head instruction address.
redirect_valid  in  1  flush the FIFO and restart fetch at redirect_pc.
redirect_pc  in  32  new fetch address.
halt  in  1  suppress new fetches while high; the FIFO keeps draining.
fetch_fault  out  1  sticky flag: the fetch address was out of range or misaligned.
fault_pc  out  32  the offending PC, latched on fault entry.
fetch_count  out  32  count of enqueued instructions; wraps modulo 2^32.

Behaviour:
- Reset, synchronous and active-high on clk:
  - pc <= RESET_PC; FIFO emptied.
  - out_valid=0, fetch_fault=0, fault_pc=0, fetch_count=0.
  - out_instr and out_pc read 0 while the FIFO is empty.
- iaddr = pc at all times. The memory truncates addresses, so range checking is done here, never relied on downstream.
- Fetch attempt occurs in a cycle when all of the following hold: !rst, !redirect_valid, !halt, !fetch_fault, and space is available.
  - Space is available when count<DEPTH, or when count==DEPTH and a dequeue happens in the same cycle.
- On a fetch attempt:
  - If pc>=IMEM_BYTES or pc[1:0]!=0: no enqueue; fetch_fault<=1; fault_pc<=pc; pc holds.
  - Otherwise: enqueue {pc, idata}; pc<=pc+4 (32-bit wrap); fetch_count<=fetch_count+1.
- Dequeue occurs when out_valid && out_ready. The head advances and count decrements, unless an enqueue happens in the same cycle, in which case count is unchanged.
- Latency:
  - An instruction fetched in cycle N is visible on out_* in cycle N+1.
  - After reset deasserts in cycle 0, out_valid=1 in cycle 1 with out_pc=RESET_PC.
  - Sustained throughput is 1 instruction per cycle when out_ready is held high.
- Redirect has the highest priority after rst:
  - FIFO cleared; pc<=redirect_pc; no fetch attempt that cycle.
  - out_valid=0 in cycle N+1; the first instruction from the new path is valid in cycle N+2.
  - A handshake on the head in the redirect cycle counts as accepted by the consumer, but it does not prevent the flush.
  - Redirect clears fetch_fault. A misaligned or out-of-range redirect_pc faults on the next fetch attempt.
- Fault handling:
  - fetch_fault is sticky until redirect or rst.
  - Entries already in the FIFO still drain normally.
- Halt: no fetch attempts and pc holds; output handshake is unaffected. Deasserting halt resumes fetching at the held pc the same cycle.
- Backpressure: if out_ready=0 with the FIFO full, pc holds and iaddr is stable.
- FIFO structure: circular buffer with rd/wr pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap naturally.
- There is no FSM beyond the fault flag. The states are RUN, HALTED (halt=1) and FAULT (fetch_fault=1); priority is rst > redirect > fault > halt.

Decomposition:
- IMEM_SIZE and IMEM_ADDR_WIDTH come from the shared macro include; no new global constants are added.
- One sub-module is natural: fetch_fifo, a parameterised synchronous FIFO.
  - Inputs: flush, push, pop, {pc, instr} data.
  - Outputs: count, full, empty.
  - It is reusable for later prefetch or branch-queue work.

Test Plan:
- Reset, then out_ready=1 for 6 cycles with memory words k*0x11111111 → out_valid in cycle 1; out_pc sequence 0,4,8,12,16; out_instr matches memory; fetch_count=6 after 6 fetch cycles.
- out_ready=0 for 5 cycles after reset (DEPTH=2) → exactly 2 entries (pc 0,4); iaddr holds at 8; out_pc stays 0. Raise out_ready → 0,4,8 delivered on consecutive cycles.
- Redirect to 0x40 while the FIFO holds pc 8,12 → out_valid=0 next cycle; next delivered out_pc=0x40 two cycles after the redirect; no stale pc 8 or 12 appears.
- Run to pc=IMEM_BYTES-4 then continue → the last word is delivered; fetch_fault=1 with fault_pc=IMEM_BYTES; no further enqueues. Redirect to 0 → fault clears and fetch resumes at 0.
- Redirect to 0x42 → fetch_fault=1, fault_pc=0x42, nothing enqueued. Assert rst mid-run → all outputs take reset values and pc=RESET_PC the next cycle.
- halt=1 for 3 cycles with out_ready=1 → the FIFO drains to empty; iaddr is constant; fetch_count is unchanged. After halt drops, fetching resumes at the held pc.
